// File: rtl/fft_input_packer.sv
// -----------------------------------------------------------------------------
// fft_input_packer
//
// Serial-to-parallel front end for the 512-point FFT pipeline. One complex
// sample is accepted per qualified cycle. Every 16 consecutive samples are
// packed into a 16-lane bundle, which is presented with a one-cycle
// din_valid pulse and frame_start / frame_done markers. A sync sample forces
// realignment to lane 0 of bundle 0. Any partial bundle or frame is
// discarded at that point and flagged on the sticky align_err.
//
// Optional feature: define PACKER_CONJ_EN to add the fft_mode port. With
// fft_mode=1, each accepted s_q is negated with saturation (IFFT conjugation).
// Without the macro the port is absent and s_q passes unmodified.
//
// Ports
//   clk          in   rising-edge clock
//   rstn         in   synchronous active-low reset
//   s_i, s_q     in   serial sample, signed WIDTH bits
//   s_valid      in   sample qualifier
//   s_sync       in   qualified sample is sample 0 of a frame
//   fft_mode     in   1 = conjugate input (only with PACKER_CONJ_EN)
//   out_i, out_q out  packed lanes; lane n = n-th sample of the bundle
//   din_valid    out  one-cycle bundle valid
//   frame_start  out  with din_valid on bundle 0
//   frame_done   out  with din_valid on the last bundle of the frame
//   align_err    out  sticky; a sync discarded partial data
// -----------------------------------------------------------------------------
module fft_input_packer #(
   parameter int WIDTH  = 9,
   parameter int LANES  = 16,
   parameter int POINTS = 512
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic signed [WIDTH-1:0] s_i,
   input  logic signed [WIDTH-1:0] s_q,
   input  logic                    s_valid,
   input  logic                    s_sync,
`ifdef PACKER_CONJ_EN
   input  logic                    fft_mode,
`endif
   output logic signed [WIDTH-1:0] out_i [0:LANES-1],
   output logic signed [WIDTH-1:0] out_q [0:LANES-1],
   output logic                    din_valid,
   output logic                    frame_start,
   output logic                    frame_done,
   output logic                    align_err
);

   localparam int BLOCKS = POINTS / LANES;

   logic [3:0]              lane_cnt_reg;
   logic [4:0]              blk_cnt_reg;
   logic                    din_valid_reg;
   logic                    frame_start_reg;
   logic                    frame_done_reg;
   logic                    align_err_reg;

   logic signed [WIDTH-1:0] stg_i_reg [0:LANES-2];
   logic signed [WIDTH-1:0] stg_q_reg [0:LANES-2];
   logic signed [WIDTH-1:0] out_i_reg [0:LANES-1];
   logic signed [WIDTH-1:0] out_q_reg [0:LANES-1];

   logic signed [WIDTH-1:0] q_in;
   logic                    sync_hit;
   logic                    pack;
   logic [3:0]              wr_lane;

   // ---------------------------------------------------------------------
   // Imaginary-part conditioning
   // ---------------------------------------------------------------------
`ifdef PACKER_CONJ_EN
   localparam logic signed [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};

   // The most negative code has no positive counterpart, so it clips to max.
   always_comb begin
      q_in = s_q;
      if (fft_mode) begin
         q_in = (s_q == Q_MIN) ? Q_MAX : -s_q;
      end
   end
`else
   assign q_in = s_q;
`endif

   // ---------------------------------------------------------------------
   // Control decode
   // ---------------------------------------------------------------------
   // A sync sample always takes lane 0, so it can never complete a bundle,
   // even if the counters were sitting at lane 15.
   assign sync_hit = s_valid & s_sync;
   assign pack     = s_valid & ~s_sync & (lane_cnt_reg == 4'(LANES-1));
   assign wr_lane  = sync_hit ? 4'd0 : lane_cnt_reg;

   // ---------------------------------------------------------------------
   // Counters, pulse outputs and sticky error
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         lane_cnt_reg    <= '0;
         blk_cnt_reg     <= '0;
         din_valid_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
         align_err_reg   <= 1'b0;
      end else begin
         din_valid_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
         if (sync_hit) begin
            // Sync at a natural frame boundary is legal; anywhere else it
            // throws away buffered samples.
            if (lane_cnt_reg != 4'd0 || blk_cnt_reg != 5'd0) begin
               align_err_reg <= 1'b1;
            end
            lane_cnt_reg <= 4'd1;
            blk_cnt_reg  <= 5'd0;
         end else if (s_valid) begin
            if (pack) begin
               din_valid_reg   <= 1'b1;
               frame_start_reg <= (blk_cnt_reg == 5'd0);
               frame_done_reg  <= (blk_cnt_reg == 5'(BLOCKS-1));
               lane_cnt_reg    <= 4'd0;
               blk_cnt_reg     <= blk_cnt_reg + 5'd1;
            end else begin
               lane_cnt_reg <= lane_cnt_reg + 4'd1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Staging lanes 0..LANES-2
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < LANES-1; gi++) begin : g_stage
         always_ff @(posedge clk) begin
            if (!rstn) begin
               stg_i_reg[gi] <= '0;
               stg_q_reg[gi] <= '0;
            end else if (s_valid && wr_lane == 4'(gi)) begin
               stg_i_reg[gi] <= s_i;
               stg_q_reg[gi] <= q_in;
            end
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Output lanes: loaded only on the packing edge, held otherwise. The
   // last lane bypasses staging and takes the current sample directly.
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_out
         if (gi == LANES-1) begin : g_last
            always_ff @(posedge clk) begin
               if (!rstn) begin
                  out_i_reg[gi] <= '0;
                  out_q_reg[gi] <= '0;
               end else if (pack) begin
                  out_i_reg[gi] <= s_i;
                  out_q_reg[gi] <= q_in;
               end
            end
         end else begin : g_staged
            always_ff @(posedge clk) begin
               if (!rstn) begin
                  out_i_reg[gi] <= '0;
                  out_q_reg[gi] <= '0;
               end else if (pack) begin
                  out_i_reg[gi] <= stg_i_reg[gi];
                  out_q_reg[gi] <= stg_q_reg[gi];
               end
            end
         end
         assign out_i[gi] = out_i_reg[gi];
         assign out_q[gi] = out_q_reg[gi];
      end
   endgenerate

   assign din_valid   = din_valid_reg;
   assign frame_start = frame_start_reg;
   assign frame_done  = frame_done_reg;
   assign align_err   = align_err_reg;

endmodule

// File: tb/tb_fft_input_packer.sv
module tb_fft_input_packer;

   localparam int WIDTH = 9;
   localparam int LANES = 16;

   logic                    clk = 1'b0;
   logic                    rstn = 1'b0;
   logic signed [WIDTH-1:0] s_i = '0;
   logic signed [WIDTH-1:0] s_q = '0;
   logic                    s_valid = 1'b0;
   logic                    s_sync = 1'b0;
`ifdef PACKER_CONJ_EN
   logic                    fft_mode = 1'b0;
`endif
   logic signed [WIDTH-1:0] out_i [0:LANES-1];
   logic signed [WIDTH-1:0] out_q [0:LANES-1];
   logic                    din_valid;
   logic                    frame_start;
   logic                    frame_done;
   logic                    align_err;

   int total = 0;
   int bad   = 0;
   int exp_i [0:LANES-1];
   int exp_q [0:LANES-1];
   int pulses;
   int misplaced;

   fft_input_packer #(.WIDTH(WIDTH), .LANES(LANES), .POINTS(512)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .s_i        (s_i),
      .s_q        (s_q),
      .s_valid    (s_valid),
      .s_sync     (s_sync),
`ifdef PACKER_CONJ_EN
      .fft_mode   (fft_mode),
`endif
      .out_i      (out_i),
      .out_q      (out_q),
      .din_valid  (din_valid),
      .frame_start(frame_start),
      .frame_done (frame_done),
      .align_err  (align_err)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_lanes(input string tag);
      for (int n = 0; n < LANES; n++) begin
         chk($sformatf("%s out_i[%0d]", tag, n), out_i[n], exp_i[n]);
         chk($sformatf("%s out_q[%0d]", tag, n), out_q[n], exp_q[n]);
      end
   endtask

   task automatic send(input int vi, input int vq, input logic sync);
      s_valid = 1'b1;
      s_i     = WIDTH'(vi);
      s_q     = WIDTH'(vq);
      s_sync  = sync;
      tick();
   endtask

   task automatic idle(input logic sync);
      s_valid = 1'b0;
      s_sync  = sync;
      tick();
      s_sync  = 1'b0;
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      s_sync  = 1'b0;
      rstn    = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   initial begin
      // ---------------- reset state ----------------
      do_reset();
      for (int n = 0; n < LANES; n++) begin
         exp_i[n] = 0;
         exp_q[n] = 0;
      end
      chk_lanes("reset");
      chk("reset din_valid", din_valid, 0);
      chk("reset frame_start", frame_start, 0);
      chk("reset frame_done", frame_done, 0);
      chk("reset align_err", align_err, 0);

      // ---------------- basic bundle: i=k, q=-k ----------------
      for (int k = 0; k < LANES; k++) begin
         send(k, -k, 1'b0);
         if (k == LANES-2) chk("basic no early pulse", din_valid, 0);
      end
      s_valid = 1'b0;
      for (int n = 0; n < LANES; n++) begin
         exp_i[n] = n;
         exp_q[n] = -n;
      end
      chk("basic din_valid", din_valid, 1);
      chk("basic frame_start", frame_start, 1);
      chk("basic frame_done", frame_done, 0);
      chk_lanes("basic");
      idle(1'b0);
      chk("basic pulse ends", din_valid, 0);
      chk("basic hold out_i[7]", out_i[7], 7);
      $display("txn basic bundle done");

      // ---------------- full frame, sync on first ----------------
      do_reset();
      pulses = 0;
      misplaced = 0;
      for (int k = 0; k < 512; k++) begin
         send(k % 200, -(k % 100), (k == 0));
         if (din_valid) begin
            pulses++;
            if (k % 16 != 15) misplaced++;
            chk($sformatf("frame frame_start k=%0d", k), frame_start, (k == 15));
            chk($sformatf("frame frame_done k=%0d", k), frame_done, (k == 511));
         end else if (k % 16 == 15) begin
            misplaced++;
         end
      end
      chk("frame pulse count", pulses, 32);
      chk("frame misplaced pulses", misplaced, 0);
      chk("frame align_err", align_err, 0);
      for (int n = 0; n < LANES; n++) begin
         exp_i[n] = (496 + n) % 200;
         exp_q[n] = -((496 + n) % 100);
      end
      chk_lanes("frame last");
      // Sync exactly on the natural boundary is legal.
      send(3, 3, 1'b1);
      s_valid = 1'b0;
      chk("boundary sync no pulse", din_valid, 0);
      chk("boundary sync align_err", align_err, 0);
      $display("txn full frame done pulses=%0d", pulses);

      // ---------------- gapped input, stray sync during a gap ----------------
      do_reset();
      for (int k = 0; k < LANES; k++) begin
         send(k + 20, -(k + 1), 1'b0);
         if (k == LANES-1) begin
            chk("gap din_valid", din_valid, 1);
            chk("gap frame_start", frame_start, 1);
         end
         idle(k == 8);
         chk($sformatf("gap idle din_valid k=%0d", k), din_valid, 0);
      end
      for (int n = 0; n < LANES; n++) begin
         exp_i[n] = n + 20;
         exp_q[n] = -(n + 1);
      end
      chk_lanes("gap");
      chk("gap align_err", align_err, 0);
      $display("txn gapped bundle done");

      // ---------------- misaligned sync ----------------
      do_reset();
      pulses = 0;
      for (int k = 0; k < 7; k++) begin
         send(k + 1, k + 1, 1'b0);
         if (din_valid) pulses++;
      end
      send(100, -100, 1'b1);
      if (din_valid) pulses++;
      chk("sync align_err set", align_err, 1);
      for (int k = 1; k < LANES; k++) begin
         send(100 + k, -100 - k, 1'b0);
         if (din_valid) pulses++;
      end
      s_valid = 1'b0;
      chk("sync pulse count", pulses, 1);
      chk("sync din_valid", din_valid, 1);
      chk("sync frame_start", frame_start, 1);
      for (int n = 0; n < LANES; n++) begin
         exp_i[n] = 100 + n;
         exp_q[n] = -100 - n;
      end
      chk_lanes("sync");
      for (int k = 0; k < 5; k++) idle(1'b0);
      chk("sync align_err sticky", align_err, 1);
      do_reset();
      chk("sync align_err cleared", align_err, 0);
      $display("txn misaligned sync done");

      // ---------------- reset mid-bundle ----------------
      for (int k = 0; k < 10; k++) send(50 + k, 60 + k, 1'b0);
      do_reset();
      chk("midrst din_valid", din_valid, 0);
      pulses = 0;
      for (int k = 0; k < LANES; k++) begin
         send(k - 8, 2 * k - 15, 1'b0);
         if (din_valid) pulses++;
      end
      s_valid = 1'b0;
      for (int n = 0; n < LANES; n++) begin
         exp_i[n] = n - 8;
         exp_q[n] = 2 * n - 15;
      end
      chk("midrst pulse count", pulses, 1);
      chk("midrst pulse on last", din_valid, 1);
      chk_lanes("midrst");
      idle(1'b0);
      chk("midrst no extra pulse", din_valid, 0);
      $display("txn reset mid-bundle done");

      // ---------------- extreme imaginary values ----------------
      do_reset();
`ifdef PACKER_CONJ_EN
      fft_mode = 1'b1;
`endif
      for (int k = 0; k < LANES; k++) begin
         send(k, (k == 0) ? -256 : ((k == 1) ? 5 : 0), 1'b0);
      end
      s_valid = 1'b0;
      for (int n = 0; n < LANES; n++) begin
         exp_i[n] = n;
         exp_q[n] = 0;
      end
`ifdef PACKER_CONJ_EN
      exp_q[0] = 255;
      exp_q[1] = -5;
`else
      exp_q[0] = -256;
      exp_q[1] = 5;
`endif
      chk("conj din_valid", din_valid, 1);
      chk_lanes("conj");
      $display("txn imaginary extremes done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
